// File: rtl/serial_full_adder.sv
// Multi-cycle adder: WIDTH-bit A + B + CIN computed DIGIT bits per clock with a registered carry.
// Optional macro SERIAL_FULL_ADDER_SUB_EN adds a 'sub' input selecting A + ~B + 1.
module serial_full_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_FULL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_err
    $error("serial_full_adder: illegal WIDTH/DIGIT combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               c_q, c_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;

  logic [DIGIT:0]     slice;
  logic [WIDTH-1:0]   dig_ext;
  logic [WIDTH-1:0]   res_next;
  logic               sub_sel;

`ifdef SERIAL_FULL_ADDER_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready is high only in IDLE, out_valid only in DONE.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;
  assign sum       = sum_q;
  assign carry     = carry_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      step_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      step_q  <= step_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    step_d  = step_q;
    sum_d   = sum_q;
    carry_d = carry_q;

    slice    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(c_q);
    dig_ext  = WIDTH'(slice[DIGIT-1:0]);
    // New digit enters at the MSB end so after STEPS shifts the LSB digit sits at bit 0.
    res_next = (res_q >> DIGIT) | (dig_ext << (WIDTH - DIGIT));

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub_sel ? ~b : b;
          c_d     = sub_sel ? 1'b1 : cin;
          res_d   = '0;
          step_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d    = a_q >> DIGIT;
        b_d    = b_q >> DIGIT;
        c_d    = slice[DIGIT];
        res_d  = res_next;
        step_d = step_q + CNT_W'(1);
        if (step_q == CNT_W'(STEPS - 1)) begin
          sum_d   = res_next;
          carry_d = slice[DIGIT];
          step_d  = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_full_adder.sv
// Randomised and directed checks of serial_full_adder (DIGIT=1 and DIGIT=4 instances)
// against a plain-arithmetic reference model.
module tb_serial_full_adder;

  logic        clk = 1'b0;
  logic        reset;

  logic        in_valid, in_ready, cin, out_valid, out_ready, carry, busy;
  logic [15:0] a, b, sum;
  logic [1:0]  dbg;

  logic        d4_in_valid, d4_in_ready, d4_cin, d4_out_valid, d4_out_ready, d4_carry, d4_busy;
  logic [15:0] d4_a, d4_b, d4_sum;
  logic [1:0]  d4_dbg;

`ifdef SERIAL_FULL_ADDER_SUB_EN
  logic        sub, d4_sub;
`endif

  int          n_chk = 0;
  int          n_bad = 0;
  logic [16:0] exp_q[$];
  logic [15:0] last_sum  = '0;
  logic        last_carry = 1'b0;

  always #5 clk = ~clk;

  serial_full_adder #(.WIDTH(16), .DIGIT(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef SERIAL_FULL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .carry(carry),
    .busy(busy), .dbg_state(dbg)
  );

  serial_full_adder #(.WIDTH(16), .DIGIT(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
    .a(d4_a), .b(d4_b), .cin(d4_cin),
`ifdef SERIAL_FULL_ADDER_SUB_EN
    .sub(d4_sub),
`endif
    .out_valid(d4_out_valid), .out_ready(d4_out_ready), .sum(d4_sum), .carry(d4_carry),
    .busy(d4_busy), .dbg_state(d4_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] ref_add(input logic [15:0] av, input logic [15:0] bv,
                                          input logic cv, input logic sv);
    if (sv) return {1'b0, av} + {1'b0, ~bv} + 17'd1;
    return {1'b0, av} + {1'b0, bv} + 17'(cv);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                        input logic sv, input int hold);
    int          cyc;
    logic [16:0] e;
    cyc = 0;
    while (!in_ready && cyc < 50) begin tick(); cyc++; end
    chk("idle_in_ready", in_ready, 1);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
`ifdef SERIAL_FULL_ADDER_SUB_EN
    sub = sv;
`endif
    exp_q.push_back(ref_add(av, bv, cv, sv));
    tick();
    chk("accept_in_ready", in_ready, 0);
    chk("accept_busy", busy, 1);
    // Keep offering fresh operands during RUN; none of them may be taken.
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      chk("run_in_ready", in_ready, 0);
      chk("run_sum_held", sum, last_sum);
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("latency", cyc, 16);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h0;
    chk("sum", sum, e[15:0]);
    chk("carry", carry, e[16]);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_out_valid", out_valid, 1);
      chk("hold_sum", sum, e[15:0]);
      chk("hold_carry", carry, e[16]);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_sum", sum, e[15:0]);
    chk("post_carry", carry, e[16]);
    last_sum = e[15:0];
    last_carry = e[16];
  endtask

  task automatic run_op4(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                         input logic sv);
    int          cyc;
    logic [16:0] e;
    chk("d4_idle_in_ready", d4_in_ready, 1);
    d4_a = av; d4_b = bv; d4_cin = cv; d4_in_valid = 1'b1;
`ifdef SERIAL_FULL_ADDER_SUB_EN
    d4_sub = sv;
`endif
    exp_q.push_back(ref_add(av, bv, cv, sv));
    tick();
    d4_in_valid = 1'b0;
    cyc = 0;
    while (!d4_out_valid && cyc < 50) begin tick(); cyc++; end
    chk("d4_latency", cyc, 4);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h0;
    chk("d4_sum", d4_sum, e[15:0]);
    chk("d4_carry", d4_carry, e[16]);
    d4_out_ready = 1'b1;
    tick();
    d4_out_ready = 1'b0;
    chk("d4_post_in_ready", d4_in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_valid = 0; a = 0; b = 0; cin = 0; out_ready = 0;
    d4_in_valid = 0; d4_a = 0; d4_b = 0; d4_cin = 0; d4_out_ready = 0;
`ifdef SERIAL_FULL_ADDER_SUB_EN
    sub = 0; d4_sub = 0;
`endif
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_carry", carry, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg, 0);
    chk("d4_rst_in_ready", d4_in_ready, 1);
    chk("d4_rst_sum", d4_sum, 0);
    reset = 1'b0;
    tick();

    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 5);
    run_op(16'h0000, 16'h0000, 1'b0, 1'b0, 1);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);

    // Abort an operation partway through RUN.
    a = 16'hABCD; b = 16'h1357; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    chk("mid_run_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_sum", sum, 0);
    chk("abort_carry", carry, 0);
    chk("abort_busy", busy, 0);
    tick();
    reset = 1'b0;
    last_sum = '0;
    last_carry = 1'b0;
    repeat (20) begin
      tick();
      chk("abort_no_out_valid", out_valid, 0);
    end
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 0);

    for (int i = 0; i < 20; i++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, int'($urandom_range(0, 3)));

    run_op4(16'h8000, 16'h8000, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++)
      run_op4(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);

`ifdef SERIAL_FULL_ADDER_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 0);
    for (int i = 0; i < 10; i++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    for (int i = 0; i < 5; i++)
      run_op4(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
